// File: rtl/riscv_pkg.sv
// Shared definitions for the M-extension multiply/divide unit:
// op encodings, FSM states and the iteration counter sizing helper.
package riscv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_e;

    // Wide enough to hold the value XLEN itself.
    function automatic int unsigned cnt_width(input int unsigned xlen);
        return $clog2(xlen) + 1;
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle of the multiply/divide unit.
interface muldiv_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;

    modport master (
        output in_valid, op, a, b, flush, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, op, a, b, flush, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring trial-subtract divide.
// hi/lo are {accumulator, multiplier} for multiply and {remainder, quotient} for divide.
module muldiv_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);
    logic [XLEN:0] sum;
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    always_comb begin
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
        rem_sh = {hi, lo[XLEN-1]};
        diff   = rem_sh - {1'b0, operand};
        if (is_div) begin
            // Remainder stays below the divisor, so diff's top bit is a clean borrow.
            if (diff[XLEN]) begin
                hi_nxt = rem_sh[XLEN-1:0];
                lo_nxt = {lo[XLEN-2:0], 1'b0};
            end else begin
                hi_nxt = diff[XLEN-1:0];
                lo_nxt = {lo[XLEN-2:0], 1'b1};
            end
        end else begin
            hi_nxt = sum[XLEN:1];
            lo_nxt = {sum[0], lo[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: FSM, counter, sign handling and handshake
// around a single-iteration datapath step.
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic clk,
    input  logic rst_n,
    muldiv_unit_if.slave bus
);
    localparam int unsigned     CNT_W    = cnt_width(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         state, state_nxt;
    md_op_e            op_in, op_q;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   hi, lo, operand, hi_nxt, lo_nxt;
    logic              neg_q;
    logic [XLEN-1:0]   result_q;
    logic              zero_q;

    logic              signed_a, signed_b, a_neg, b_neg;
    logic              div_zero, div_ovf, bypass;
    logic [XLEN-1:0]   abs_a, abs_b, bypass_res;
    logic [2*XLEN-1:0] prod, prod_c;
    logic [XLEN-1:0]   q_c, r_c, final_res;
    logic              accept, last_iter;

    assign op_in     = md_op_e'(bus.op);
    assign accept    = bus.in_valid && (state == IDLE);
    assign last_iter = (cnt == CNT_W'(1));

    always_comb begin
        signed_a = op_in inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
        signed_b = op_in inside {MD_MULH, MD_DIV, MD_REM};
        a_neg    = signed_a & bus.a[XLEN-1];
        b_neg    = signed_b & bus.b[XLEN-1];
        abs_a    = a_neg ? -bus.a : bus.a;
        abs_b    = b_neg ? -bus.b : bus.b;
        div_zero = op_in[2] && (bus.b == '0);
        div_ovf  = (op_in == MD_DIV || op_in == MD_REM) && (bus.a == MOST_NEG) && (bus.b == '1);
        bypass   = div_zero | div_ovf;
        if (div_zero)
            bypass_res = (op_in == MD_DIV || op_in == MD_DIVU) ? '1 : bus.a;
        else
            bypass_res = (op_in == MD_DIV) ? bus.a : '0;
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div  (op_q[2]),
        .hi      (hi),
        .lo      (lo),
        .operand (operand),
        .hi_nxt  (hi_nxt),
        .lo_nxt  (lo_nxt)
    );

    // Sign correction is applied to the outputs of the final iteration.
    always_comb begin
        prod   = {hi_nxt, lo_nxt};
        prod_c = neg_q ? -prod : prod;
        q_c    = neg_q ? -lo_nxt : lo_nxt;
        r_c    = neg_q ? -hi_nxt : hi_nxt;
        case (op_q)
            MD_MUL:                       final_res = prod_c[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: final_res = prod_c[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              final_res = q_c;
            default:                      final_res = r_c;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = bypass ? DONE : CALC;
            CALC:    if (last_iter) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= MD_MUL;
            neg_q    <= 1'b0;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            operand  <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else if (!bus.flush) begin
            if (accept) begin
                op_q  <= op_in;
                neg_q <= (op_in == MD_REM || op_in == MD_REMU) ? a_neg : (a_neg ^ b_neg);
                if (bypass) begin
                    result_q <= bypass_res;
                    zero_q   <= (bypass_res == '0);
                end else begin
                    hi      <= '0;
                    lo      <= op_in[2] ? abs_a : abs_b;
                    operand <= op_in[2] ? abs_b : abs_a;
                    cnt     <= CNT_W'(XLEN);
                end
            end else if (state == CALC) begin
                hi  <= hi_nxt;
                lo  <= lo_nxt;
                cnt <= cnt - CNT_W'(1);
                if (last_iter) begin
                    result_q <= final_res;
                    zero_q   <= (final_res == '0);
                end
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, abort paths and
// random operations compared against a plain-arithmetic reference model.
module tb_muldiv_unit;
    import riscv_pkg::*;

    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    muldiv_unit_if #(.XLEN(XLEN)) bus ();
    muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        int          ia, ib;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'b0, b});
        ia  = a;
        ib  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Entered and left at a negative clock edge.
    task automatic run_op(input logic [2:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                          input logic [31:0] exp, input int hold, input string tag);
        int t;
        int lat;
        bus.out_ready = (hold == 0);
        t = 0;
        while (!bus.in_ready && t < 100) begin @(negedge clk); t++; end
        check({tag, "/in_ready"}, 64'(bus.in_ready), 64'(1));
        bus.in_valid = 1'b1;
        bus.op       = op_i;
        bus.a        = a_i;
        bus.b        = b_i;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin @(negedge clk); lat++; end
        check({tag, "/latency"}, 64'(lat), 64'(exp_lat(op_i, a_i, b_i)));
        check({tag, "/result"}, 64'(bus.result), 64'(exp));
        check({tag, "/zero"}, 64'(bus.zero), 64'(exp == 0));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "/hold_valid"}, 64'(bus.out_valid), 64'(1));
            check({tag, "/hold_result"}, 64'(bus.result), 64'(exp));
            check({tag, "/hold_in_ready"}, 64'(bus.in_ready), 64'(0));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check({tag, "/drop_valid"}, 64'(bus.out_valid), 64'(0));
        check({tag, "/idle"}, 64'(bus.in_ready), 64'(1));
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;
        logic        seen;

        bus.in_valid  = 1'b0;
        bus.op        = 3'd0;
        bus.a         = '0;
        bus.b         = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        check("reset/out_valid", 64'(bus.out_valid), 64'(0));
        check("reset/result", 64'(bus.result), 64'(0));
        check("reset/zero", 64'(bus.zero), 64'(1));
        rst_n = 1'b1;
        @(negedge clk);
        check("reset/in_ready", 64'(bus.in_ready), 64'(1));

        run_op(MD_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, "mul");
        run_op(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mulhu");
        run_op(MD_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         0, "mulh");
        run_op(MD_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 0, "mulhsu");
        run_op(MD_DIV,    32'hFFFF_FFEC, 32'd6,         32'hFFFF_FFFD, 0, "div");
        run_op(MD_REM,    32'hFFFF_FFEC, 32'd6,         32'hFFFF_FFFE, 0, "rem");
        run_op(MD_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 0, "divu_by0");
        run_op(MD_REMU,   32'd1234,      32'd0,         32'd1234,      0, "remu_by0");
        run_op(MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         0, "rem_ovf");
        run_op(MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "div_ovf");
        run_op(MD_DIVU,   32'd100,       32'd7,         32'd14,        5, "backpressure");

        // Flush beats accept in the same cycle.
        bus.in_valid = 1'b1; bus.flush = 1'b1; bus.op = MD_MUL; bus.a = 32'd3; bus.b = 32'd3;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        check("flush_accept/in_ready", 64'(bus.in_ready), 64'(1));
        check("flush_accept/out_valid", 64'(bus.out_valid), 64'(0));

        // Flush during iteration 10.
        bus.in_valid = 1'b1; bus.op = MD_MUL; bus.a = 32'd9; bus.b = 32'd9;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("flush_calc/busy", 64'(bus.in_ready), 64'(0));
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_calc/in_ready", 64'(bus.in_ready), 64'(1));
        check("flush_calc/out_valid", 64'(bus.out_valid), 64'(0));
        check("flush_calc/result_kept", 64'(bus.result), 64'(14));
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("flush_calc/no_result", 64'(seen), 64'(0));

        // Reset pulse mid-calculation.
        bus.in_valid = 1'b1; bus.op = MD_DIV; bus.a = 32'd1000; bus.b = 32'd3;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_calc/out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_calc/in_ready", 64'(bus.in_ready), 64'(1));
        check("rst_calc/result", 64'(bus.result), 64'(0));
        check("rst_calc/zero", 64'(bus.zero), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_calc/in_ready_after", 64'(bus.in_ready), 64'(1));
        check("rst_calc/out_valid_after", 64'(bus.out_valid), 64'(0));

        for (int n = 0; n < 40; n++) begin
            r_op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       r_a = 32'h8000_0000;
                1:       r_a = 32'($urandom_range(0, 20));
                default: r_a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       r_b = 32'h0;
                1:       r_b = 32'hFFFF_FFFF;
                2:       r_b = 32'($urandom_range(1, 20));
                default: r_b = $urandom;
            endcase
            run_op(r_op, r_a, r_b, ref_model(r_op, r_a, r_b), int'($urandom_range(0, 2)),
                   $sformatf("rand%0d_op%0d", n, r_op));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed unfinished, expected finished");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the operand and result width; legal values are 8, 16, 32 and 64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: a request is present.
REQ-005 SHALL have port in_ready, output, 1 bit: the unit can accept a request.
REQ-006 SHALL have port op, input, 3 bits, using RV32M funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 SHALL have ports a and b, input, XLEN bits each: rs1 and rs2 operands.
REQ-008 SHALL have port flush, input, 1 bit: synchronous abort.
REQ-009 SHALL have port out_valid, output, 1 bit: result is available.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port result, output, XLEN bits: the computed value.
REQ-012 SHALL have port zero, output, 1 bit: result equals 0, same meaning as the ALU zero flag.

Function
REQ-013 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-014 SHALL assert in_ready only in IDLE; a request is accepted when in_valid and in_ready are both high at a rising edge, and op, a and b are latched at that edge.
REQ-015 SHALL, for a normal accept, go IDLE->CALC and perform exactly XLEN radix-2 iterations (shift-add for MUL*, restoring shift-subtract for DIV*/REM*), then go CALC->DONE; out_valid is therefore high XLEN+1 cycles after the accept edge.
REQ-016 SHALL bypass CALC when the divisor is zero or on signed overflow, going IDLE->DONE so out_valid is high 1 cycle after the accept edge.
REQ-017 SHALL operate on absolute values for signed ops and apply sign correction on entry to DONE: the quotient is negative iff the operand signs differ, and the remainder takes the sign of the dividend.
REQ-018 SHALL treat a as signed and b as unsigned for MULHSU.
REQ-019 SHALL return the low XLEN bits of the 2*XLEN product for MUL and the high XLEN bits for MULH, MULHSU and MULHU.
REQ-020 SHALL, on divide by zero, return all ones for DIV/DIVU and a for REM/REMU.
REQ-021 SHALL, for DIV with a = most-negative value and b = -1, return a for DIV and 0 for REM.
REQ-022 SHALL hold out_valid, result and zero stable in DONE until out_ready is high; DONE->IDLE on out_valid && out_ready.
REQ-023 SHALL keep in_ready low in the DONE cycle that completes the handshake, so a new accept happens no earlier than the following cycle.
REQ-024 SHALL, when flush is high at an edge, return to IDLE from any state, drop out_valid and discard the operation; flush takes priority over accept and over the output handshake in the same cycle.
REQ-025 SHALL leave result and zero unchanged in IDLE and CALC; only out_valid qualifies them.

Reset
REQ-026 SHALL, while rst_n is low, immediately force the state to IDLE, out_valid=0, result=0, zero=1 and clear the iteration counter and working registers.
REQ-027 SHALL abandon any in-flight operation on reset mid-CALC or mid-DONE with no result emitted; in_ready goes high in the first cycle after rst_n deasserts.

Structure
REQ-028 SHALL place the op encodings (MD_MUL..MD_REMU), the FSM state typedef and the iteration counter width function ($clog2(XLEN)+1) in the shared package riscv_pkg.
REQ-029 SHALL isolate one iteration step (shift-add or trial-subtract) in the sub-module muldiv_step; the top level owns the FSM, counter, sign handling and handshake.

Verification
REQ-030 SHALL cover MUL: a=7, b=-3 (0xFFFFFFFD) -> result 0xFFFFFFEB, out_valid at accept+33, zero=0.
REQ-031 SHALL cover MULHU: a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000 with zero=1.
REQ-032 SHALL cover DIV: a=-20, b=6 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFE.
REQ-033 SHALL cover DIVU: a=5, b=0 -> 0xFFFFFFFF; REM: a=0x80000000, b=-1 -> 0; both with out_valid at accept+1.
REQ-034 SHALL cover back-pressure: hold out_ready low for 5 cycles in DONE -> result stable and in_ready low throughout.
REQ-035 SHALL cover abort: flush at CALC iteration 10 -> IDLE next cycle, no out_valid; rst_n pulsed low mid-CALC -> immediate IDLE, result=0, zero=1.
